// File: rtl/mul_shift_unit.sv
// Sequential arithmetic helper for the neuron potential-decay datapath:
// a 32x32 iterative shift-add multiplier and a registered 32-bit barrel shifter.
module mul_shift_unit (
   input  logic        clk,
   input  logic        rst,
   input  logic        mul_start,
   input  logic [31:0] mul_a,
   input  logic [31:0] mul_b,
   output logic [63:0] mul_result,
   output logic        mul_done,
   input  logic        sh_start,
   input  logic [31:0] sh_data_in,
   input  logic [4:0]  sh_amount,
   input  logic [1:0]  sh_mode,
   output logic [31:0] sh_data_out,
   output logic        sh_done
);

   localparam int unsigned OP_W   = 32;
   localparam int unsigned PROD_W = 64;
   localparam int unsigned AMT_W  = 5;
   localparam int unsigned CNT_W  = 5;
   localparam logic [CNT_W-1:0] LAST_CNT = CNT_W'(OP_W - 1);

   localparam logic [1:0] MODE_SLL = 2'b00;
   localparam logic [1:0] MODE_SRL = 2'b01;
   localparam logic [1:0] MODE_SRA = 2'b10;
   localparam logic [1:0] MODE_ROR = 2'b11;

   typedef enum logic {
      MUL_IDLE = 1'b0,
      MUL_BUSY = 1'b1
   } mul_state_e;

   mul_state_e         state_q, state_d;
   logic [CNT_W-1:0]   cnt_q, cnt_d;
   logic [OP_W-1:0]    a_q, a_d;
   logic [OP_W-1:0]    b_q, b_d;
   logic [PROD_W-1:0]  acc_q, acc_d;
   logic [PROD_W-1:0]  result_q, result_d;
   logic               mul_done_q, mul_done_d;
   logic [OP_W-1:0]    sh_out_q, sh_out_d;
   logic               sh_done_q, sh_done_d;

   logic [PROD_W-1:0]  partial;
   logic [PROD_W-1:0]  acc_next;
   logic [OP_W-1:0]    shift_res;
   logic [2*OP_W-1:0]  rot_wide;

   // Multiplier: one partial product per cycle, product written on the last iteration
   always_comb begin
      state_d    = state_q;
      cnt_d      = cnt_q;
      a_d        = a_q;
      b_d        = b_q;
      acc_d      = acc_q;
      result_d   = result_q;
      mul_done_d = mul_done_q;
      partial    = PROD_W'(a_q) << cnt_q;
      acc_next   = acc_q + (b_q[cnt_q] ? partial : '0);

      case (state_q)
         MUL_IDLE: begin
            if (mul_start) begin
               a_d        = mul_a;
               b_d        = mul_b;
               acc_d      = '0;
               cnt_d      = '0;
               mul_done_d = 1'b0;
               state_d    = MUL_BUSY;
            end
         end
         MUL_BUSY: begin
            acc_d = acc_next;
            cnt_d = cnt_q + CNT_W'(1);
            if (cnt_q == LAST_CNT) begin
               result_d   = acc_next;
               mul_done_d = 1'b1;
               cnt_d      = '0;
               state_d    = MUL_IDLE;
            end
         end
         default: state_d = MUL_IDLE;
      endcase
   end

   // Barrel shifter; rotate uses a doubled word so bits leaving bit 0 re-enter at bit 31
   always_comb begin
      shift_res = sh_data_in;
      rot_wide  = {sh_data_in, sh_data_in} >> sh_amount;
      case (sh_mode)
         MODE_SLL: shift_res = sh_data_in << sh_amount;
         MODE_SRL: shift_res = sh_data_in >> sh_amount;
         MODE_SRA: shift_res = $unsigned($signed(sh_data_in) >>> sh_amount);
         MODE_ROR: shift_res = rot_wide[OP_W-1:0];
         default:  shift_res = sh_data_in;
      endcase
   end

   always_comb begin
      sh_out_d  = sh_out_q;
      sh_done_d = sh_done_q;
      if (sh_start) begin
         sh_out_d  = shift_res;
         sh_done_d = 1'b1;
      end
   end

   always_ff @(posedge clk) begin
      if (rst) begin
         state_q    <= MUL_IDLE;
         cnt_q      <= '0;
         a_q        <= '0;
         b_q        <= '0;
         acc_q      <= '0;
         result_q   <= '0;
         mul_done_q <= 1'b0;
         sh_out_q   <= '0;
         sh_done_q  <= 1'b0;
      end else begin
         state_q    <= state_d;
         cnt_q      <= cnt_d;
         a_q        <= a_d;
         b_q        <= b_d;
         acc_q      <= acc_d;
         result_q   <= result_d;
         mul_done_q <= mul_done_d;
         sh_out_q   <= sh_out_d;
         sh_done_q  <= sh_done_d;
      end
   end

   assign mul_result  = result_q;
   assign mul_done    = mul_done_q;
   assign sh_data_out = sh_out_q;
   assign sh_done     = sh_done_q;

   logic unused_amt_w;
   assign unused_amt_w = (AMT_W == 5) ? 1'b0 : 1'b1;

endmodule

// File: tb/tb_mul_shift_unit.sv
// Scoreboard bench for mul_shift_unit: expected products/shifts queued at start,
// popped and compared when the matching done is observed.
module tb_mul_shift_unit;

   logic        clk = 1'b0;
   logic        rst;
   logic        mul_start;
   logic [31:0] mul_a, mul_b;
   logic [63:0] mul_result;
   logic        mul_done;
   logic        sh_start;
   logic [31:0] sh_data_in;
   logic [4:0]  sh_amount;
   logic [1:0]  sh_mode;
   logic [31:0] sh_data_out;
   logic        sh_done;

   int checks = 0;
   int errors = 0;

   logic [63:0] mul_exp_q[$];
   logic [31:0] sh_exp_q[$];

   mul_shift_unit dut (
      .clk         (clk),
      .rst         (rst),
      .mul_start   (mul_start),
      .mul_a       (mul_a),
      .mul_b       (mul_b),
      .mul_result  (mul_result),
      .mul_done    (mul_done),
      .sh_start    (sh_start),
      .sh_data_in  (sh_data_in),
      .sh_amount   (sh_amount),
      .sh_mode     (sh_mode),
      .sh_data_out (sh_data_out),
      .sh_done     (sh_done)
   );

   always #5 clk = ~clk;

   task automatic check(input string tag, input logic [63:0] obs, input logic [63:0] exp);
      checks++;
      if (obs !== exp) begin
         errors++;
         $display("FAIL %s: got 0x%0h expected 0x%0h", tag, obs, exp);
      end
   endtask

   task automatic tick();
      @(posedge clk);
      #1;
   endtask

   // Bit-at-a-time reference for the shifter
   function automatic logic [31:0] sh_model(input logic [31:0] d, input int amt, input logic [1:0] mode);
      logic [31:0] r;
      for (int i = 0; i < 32; i++) begin
         case (mode)
            2'b00: r[i] = (i - amt >= 0) ? d[i - amt] : 1'b0;
            2'b01: r[i] = (i + amt < 32) ? d[i + amt] : 1'b0;
            2'b10: r[i] = (i + amt < 32) ? d[i + amt] : d[31];
            default: r[i] = d[(i + amt) % 32];
         endcase
      end
      return r;
   endfunction

   task automatic mul_launch(input logic [31:0] a, input logic [31:0] b, input logic [63:0] exp);
      mul_a = a;
      mul_b = b;
      mul_start = 1'b1;
      mul_exp_q.push_back(exp);
      tick();
      mul_start = 1'b0;
      mul_a = $urandom;
      mul_b = $urandom;
   endtask

   // Called just after the start edge N; done must rise exactly at edge N+32
   task automatic mul_wait_done(input string tag, input logic [63:0] prev);
      logic early;
      logic [63:0] exp;
      early = 1'b0;
      check({tag, "_drop"}, 64'(mul_done), 64'd0);
      check({tag, "_hold"}, mul_result, prev);
      for (int k = 1; k < 32; k++) begin
         tick();
         if (mul_done) early = 1'b1;
      end
      check({tag, "_early"}, 64'(early), 64'd0);
      tick();
      check({tag, "_done"}, 64'(mul_done), 64'd1);
      if (mul_exp_q.size() == 0) begin
         check({tag, "_sb_empty"}, 64'd1, 64'd0);
      end else begin
         exp = mul_exp_q.pop_front();
         check({tag, "_result"}, mul_result, exp);
      end
   endtask

   task automatic sh_launch(input logic [31:0] d, input logic [4:0] amt, input logic [1:0] mode);
      sh_data_in = d;
      sh_amount  = amt;
      sh_mode    = mode;
      sh_start   = 1'b1;
      sh_exp_q.push_back(sh_model(d, int'(amt), mode));
   endtask

   task automatic sh_collect(input string tag);
      logic [31:0] exp;
      check({tag, "_done"}, 64'(sh_done), 64'd1);
      if (sh_exp_q.size() == 0) begin
         check({tag, "_sb_empty"}, 64'd1, 64'd0);
      end else begin
         exp = sh_exp_q.pop_front();
         check({tag, "_out"}, 64'(sh_data_out), 64'(exp));
      end
   endtask

   task automatic sh_op(input string tag, input logic [31:0] d, input logic [4:0] amt,
                        input logic [1:0] mode, input logic [31:0] literal_exp);
      sh_launch(d, amt, mode);
      tick();
      sh_start   = 1'b0;
      sh_data_in = $urandom;
      check({tag, "_lit"}, 64'(sh_data_out), 64'(literal_exp));
      sh_collect(tag);
   endtask

   initial begin
      logic stayed;
      logic spurious;
      rst = 1'b1;
      mul_start = 1'b0;
      mul_a = '0;
      mul_b = '0;
      sh_start = 1'b0;
      sh_data_in = '0;
      sh_amount = '0;
      sh_mode = '0;
      tick();
      tick();
      rst = 1'b0;
      check("rst_mul_result", mul_result, 64'd0);
      check("rst_mul_done", 64'(mul_done), 64'd0);
      check("rst_sh_out", 64'(sh_data_out), 64'd0);
      check("rst_sh_done", 64'(sh_done), 64'd0);

      // Small operands, then sticky done
      mul_launch(32'd7, 32'd9, 64'd63);
      mul_wait_done("mul_7x9", 64'd0);
      stayed = 1'b1;
      for (int k = 0; k < 10; k++) begin
         tick();
         if (!mul_done || mul_result !== 64'd63) stayed = 1'b0;
      end
      check("mul_sticky", 64'(stayed), 64'd1);

      // Maximum operands, then restart while done is high
      mul_launch(32'hFFFF_FFFF, 32'hFFFF_FFFF, 64'hFFFF_FFFE_0000_0001);
      mul_wait_done("mul_max", 64'd63);
      mul_launch(32'h10, 32'h10, 64'h100);
      mul_wait_done("mul_restart", 64'hFFFF_FFFE_0000_0001);

      // Start while busy is ignored
      mul_launch(32'd11, 32'd13, 64'd143);
      mul_a = 32'd1000;
      mul_b = 32'd1000;
      mul_start = 1'b1;
      mul_wait_done("mul_busy_ign", 64'h100);
      mul_start = 1'b0;
      tick();

      // Reset mid-operation aborts and produces no done
      mul_launch(32'd123, 32'd456, 64'd56088);
      for (int k = 0; k < 9; k++) tick();
      rst = 1'b1;
      tick();
      rst = 1'b0;
      void'(mul_exp_q.pop_front());
      sh_exp_q.delete();
      check("mul_abort_result", mul_result, 64'd0);
      check("mul_abort_done", 64'(mul_done), 64'd0);
      spurious = 1'b0;
      for (int k = 0; k < 40; k++) begin
         tick();
         if (mul_done) spurious = 1'b1;
      end
      check("mul_abort_nodone", 64'(spurious), 64'd0);
      mul_launch(32'd3, 32'd5, 64'd15);
      mul_wait_done("mul_3x5", 64'd0);

      // Shifter directed cases
      sh_op("srl", 32'h8000_0000, 5'd3, 2'b01, 32'h1000_0000);
      sh_op("sra", 32'h8000_0000, 5'd3, 2'b10, 32'hF000_0000);
      sh_op("sll", 32'h0000_0001, 5'd1, 2'b00, 32'h0000_0002);
      sh_op("ror", 32'h0000_0001, 5'd1, 2'b11, 32'h8000_0000);
      for (int m = 0; m < 4; m++)
         sh_op($sformatf("zero_m%0d", m), 32'hA5A5_1234, 5'd0, 2'(m), 32'hA5A5_1234);
      sh_op("sll31", 32'h0000_0003, 5'd31, 2'b00, 32'h8000_0000);
      sh_op("ror31", 32'h0000_0001, 5'd31, 2'b11, 32'h0000_0002);

      // Randomised shifts against the bit-level model
      for (int k = 0; k < 24; k++) begin
         sh_launch($urandom, 5'($urandom_range(0, 31)), 2'($urandom_range(0, 3)));
         tick();
         sh_start = 1'b0;
         sh_collect($sformatf("sh_rand%0d", k));
      end

      // Concurrent starts
      rst = 1'b1;
      tick();
      rst = 1'b0;
      sh_launch(32'h40, 5'd3, 2'b01);
      mul_a = 32'd5;
      mul_b = 32'h40;
      mul_start = 1'b1;
      mul_exp_q.push_back(64'h140);
      tick();
      mul_start = 1'b0;
      sh_start = 1'b0;
      check("conc_sh_lit", 64'(sh_data_out), 64'd8);
      sh_collect("conc_sh");
      mul_wait_done("conc_mul", 64'd0);
      check("conc_sh_sticky", 64'(sh_done), 64'd1);
      rst = 1'b1;
      tick();
      rst = 1'b0;
      check("final_rst_mul_done", 64'(mul_done), 64'd0);
      check("final_rst_sh_done", 64'(sh_done), 64'd0);
      check("final_rst_sh_out", 64'(sh_data_out), 64'd0);

      $display("CHECKS %0d ERRORS %0d", checks, errors);
      $finish;
   end

endmodule

// File: doc/mul_shift_unit.md
Name: mul_shift_unit

Overview:
- Sequential arithmetic helper used by the neuron potential-decay datapath.
- Contains two independent engines with a common clock and reset:
  - a 32x32 unsigned iterative shift-add multiplier with a 64-bit product;
  - a 32-bit registered barrel shifter.
- Each engine has its own start/done handshake. Callers sample `done` as a level.
- Callers reset the unit at every time step to clear `done`.

Parameters:
- None. All widths are fixed: 32-bit operands, 64-bit product, 5-bit shift amount.

Ports:
- clk  input  1  clock; all state changes on the rising edge.
- rst  input  1  reset; synchronous, active-high.
- mul_start  input  1  multiplier start request, sampled on the clk edge.
- mul_a  input  32  multiplicand (unsigned), latched at accepted start.
- mul_b  input  32  multiplier (unsigned), latched at accepted start.
- mul_result  output  64  product mul_a*mul_b; registered.
- mul_done  output  1  product valid; sticky level.
- sh_start  input  1  shifter start request.
- sh_data_in  input  32  shift operand, latched at accepted start.
- sh_amount  input  5  shift distance, 0..31.
- sh_mode  input  2  00 logical left, 01 logical right, 10 arithmetic right, 11 rotate right.
- sh_data_out  output  32  shifted value; registered.
- sh_done  output  1  shift result valid; sticky level.

Behaviour:
- Reset: when rst is high at a clk edge:
  - mul_result=0, mul_done=0, sh_data_out=0, sh_done=0;
  - multiplier returns to IDLE, iteration counter=0.
  - rst has priority over start in the same cycle.
- Multiplier FSM states: IDLE, BUSY.
  - IDLE + mul_start=1 at edge N:
    - latch A and B;
    - clear the accumulator;
    - clear mul_done;
    - go to BUSY with count=0.
  - BUSY, one iteration per cycle:
    - if B[count]=1, add (A << count) into the 64-bit accumulator;
    - count increments.
  - After 32 iterations:
    - mul_result = accumulator, which is exactly A*B with no truncation;
    - mul_done=1 at edge N+32;
    - state returns to IDLE.
  - mul_start while BUSY is ignored; operand changes while BUSY have no effect.
  - mul_start in IDLE with mul_done=1 starts a new operation:
    - mul_done drops at the next edge;
    - mul_result keeps the previous value until the new product is written.
  - mul_done stays high until the next accepted start or rst.
  - rst mid-BUSY aborts the operation: outputs are zeroed and no done pulse is produced.
- Shifter:
  - sh_start=1 at edge N: sh_data_out is computed from sh_data_in, sh_amount and sh_mode sampled at that edge.
  - sh_data_out and sh_done=1 are valid after edge N (1-cycle latency).
  - sh_done stays high until rst.
  - Re-starting while sh_done=1 updates sh_data_out at that edge; sh_done remains 1.
  - Mode 10 replicates data_in[31] into vacated bits.
  - Mode 11 wraps bits shifted out of bit 0 into bit 31.
  - sh_amount=0 passes data through unchanged in every mode.
- The two engines are fully independent. Simultaneous starts are both accepted.
- No X propagation: both outputs are defined from reset onward.

Test Plan:
- Multiplier, small operands: rst, then mul_start with A=7, B=9 for 1 cycle -> mul_done=0 for 31 edges, then mul_result=63 with mul_done=1 at edge N+32; mul_done stays 1 for 10 further cycles.
- Multiplier, maximum operands: A=B=0xFFFFFFFF -> mul_result=0xFFFFFFFE00000001. Then A=0x10, B=0x10 restart -> mul_done falls, then 0x100.
- Multiplier, reset mid-operation: assert rst at cycle 10 of BUSY -> mul_result=0, mul_done=0, and no done follows. A fresh start with A=3, B=5 -> 15.
- Shifter, right shifts: data_in=0x80000000, amount=3 -> mode 01 gives 0x10000000 and mode 10 gives 0xF0000000, each with sh_done=1 one edge after start.
- Shifter, left/rotate/zero: data_in=0x00000001, amount=1 -> mode 00 gives 0x00000002, mode 11 gives 0x80000000. amount=0 in any mode -> output equals input.
- Concurrency: both starts in the same cycle (A=5, B=0x40, shift of 0x40 right by 3) -> sh_data_out=8 with sh_done after 1 edge; mul_result=0x140 with mul_done after 32 edges. A subsequent rst clears both done flags.
